// File: rtl/cpu_pkg.sv
// Shared CPU types: register-index and data widths, writeback FSM states, and the
// buffered writeback entry layout.
package cpu_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  typedef enum logic {
    NORMAL = 1'b0,
    STARVE = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic [REG_W-1:0]  dst;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding memory-side writeback entries.
// A push is allowed while full when a pop happens in the same cycle.
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push_i,
  input  wb_entry_t din_i,
  input  logic      pop_i,
  output wb_entry_t head_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t          mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               do_push, do_pop;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: pointers alone define which slots are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between the ALU and buffered memory
// results, with starvation-forced stalls. Optional overflow flag: WB_OVERFLOW_EN.
module wb_port_arbiter
  import cpu_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [REG_W-1:0]  alu_dst,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              alu_ovf,
  input  logic              alu_ovf_chk,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [REG_W-1:0]  mem_dst,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              pend_set,
  input  logic [REG_W-1:0]  pend_dst,
  output logic [31:0]       busy_mask,
  output logic              alu_stall,
  output logic              regwrite,
  output logic [REG_W-1:0]  wrreg,
  output logic [DATA_W-1:0] wrdata,
  output logic [1:0]        of_control
);

  localparam int             WAIT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(STARVE_LIMIT);

  wb_state_e         state_q;
  logic [WAIT_W-1:0] wait_q;
  logic              alu_stall_q;

  logic              fifo_full, fifo_empty;
  wb_entry_t         head, mem_entry;
  logic              alu_win, pop, push;

  logic              regwrite_q, regwrite_d;
  logic [REG_W-1:0]  wrreg_q, wrreg_d;
  logic [DATA_W-1:0] wrdata_q, wrdata_d;
  logic [1:0]        ofc_q, ofc_d;
  logic              fifo_wr_q, fifo_wr_d;
  logic [31:0]       busy_q, busy_d;

`ifndef WB_OVERFLOW_EN
  logic unused_ovf;
  assign unused_ovf = alu_ovf ^ alu_ovf_chk;
`endif

  assign mem_ready = !fifo_full;
  assign alu_win   = alu_valid && (alu_dst != '0) && !alu_stall_q;
  assign pop       = !fifo_empty && !alu_win;
  assign push      = mem_valid && mem_ready && (mem_dst != '0);
  assign mem_entry = '{dst: mem_dst, data: mem_data};

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (mem_entry),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Starvation FSM: a head that loses STARVE_LIMIT times in a row wins the next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= NORMAL;
      wait_q      <= '0;
      alu_stall_q <= 1'b0;
    end else begin
      case (state_q)
        NORMAL: begin
          if (pop) begin
            wait_q <= '0;
          end else if (!fifo_empty) begin
            if (wait_q + WAIT_W'(1) == WAIT_LIM) begin
              state_q     <= STARVE;
              alu_stall_q <= 1'b1;
              wait_q      <= '0;
            end else begin
              wait_q <= wait_q + WAIT_W'(1);
            end
          end
        end
        default: begin
          state_q     <= NORMAL;
          alu_stall_q <= 1'b0;
          wait_q      <= '0;
        end
      endcase
    end
  end

  always_comb begin
    regwrite_d = 1'b0;
    wrreg_d    = wrreg_q;
    wrdata_d   = wrdata_q;
    ofc_d      = 2'b00;
    fifo_wr_d  = 1'b0;
    if (alu_win) begin
      regwrite_d = 1'b1;
      wrreg_d    = alu_dst;
      wrdata_d   = alu_data;
`ifdef WB_OVERFLOW_EN
      ofc_d      = {alu_ovf_chk, alu_ovf};
`endif
    end else if (pop) begin
      regwrite_d = 1'b1;
      wrreg_d    = head.dst;
      wrdata_d   = head.data;
      fifo_wr_d  = 1'b1;
    end
    // Clear follows the visible FIFO write; a new pending load on the same register wins.
    busy_d = busy_q;
    if (fifo_wr_q) busy_d[wrreg_q] = 1'b0;
    if (pend_set && (pend_dst != '0)) busy_d[pend_dst] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regwrite_q <= 1'b0;
      wrreg_q    <= '0;
      wrdata_q   <= '0;
      ofc_q      <= 2'b00;
      fifo_wr_q  <= 1'b0;
      busy_q     <= '0;
    end else begin
      regwrite_q <= regwrite_d;
      wrreg_q    <= wrreg_d;
      wrdata_q   <= wrdata_d;
      ofc_q      <= ofc_d;
      fifo_wr_q  <= fifo_wr_d;
      busy_q     <= busy_d;
    end
  end

  assign regwrite   = regwrite_q;
  assign wrreg      = wrreg_q;
  assign wrdata     = wrdata_q;
  assign of_control = ofc_q;
  assign busy_mask  = busy_q;
  assign alu_stall  = alu_stall_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus random traffic
// checked against a queue-based model of the write-port rules.
module tb_wb_port_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;
`ifdef WB_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic        clk, rst;
  logic        alu_valid, alu_ovf, alu_ovf_chk, mem_valid, pend_set;
  logic [4:0]  alu_dst, mem_dst, pend_dst;
  logic [31:0] alu_data, mem_data;
  logic        mem_ready, alu_stall, regwrite;
  logic [31:0] busy_mask, wrdata;
  logic [4:0]  wrreg;
  logic [1:0]  of_control;

  wb_port_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_dst(alu_dst), .alu_data(alu_data),
    .alu_ovf(alu_ovf), .alu_ovf_chk(alu_ovf_chk),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dst(mem_dst), .mem_data(mem_data),
    .pend_set(pend_set), .pend_dst(pend_dst), .busy_mask(busy_mask),
    .alu_stall(alu_stall), .regwrite(regwrite), .wrreg(wrreg), .wrdata(wrdata),
    .of_control(of_control)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: pending entries as a queue, plus the head's loss streak.
  typedef struct {
    logic [4:0]  dst;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  int          streak;
  bit          m_stall, m_rw, m_fw;
  logic [4:0]  m_wrreg;
  logic [31:0] m_wrdata, m_busy;
  logic [1:0]  m_ofc;

  task automatic model_reset();
    q.delete();
    streak = 0; m_stall = 0; m_rw = 0; m_fw = 0;
    m_wrreg = '0; m_wrdata = '0; m_busy = '0; m_ofc = 2'b00;
  endtask

  task automatic idle();
    alu_valid = 0; alu_dst = '0; alu_data = '0; alu_ovf = 0; alu_ovf_chk = 0;
    mem_valid = 0; mem_dst = '0; mem_data = '0; pend_set = 0; pend_dst = '0;
  endtask

  // Inputs are already applied; check pre-edge outputs, advance model and DUT, check.
  task automatic cycle();
    bit   ready, awin, pop, push;
    ent_t e;
    ready = (q.size() < DEPTH);
    check("mem_ready", {31'd0, mem_ready}, {31'd0, ready});
    check("alu_stall", {31'd0, alu_stall}, {31'd0, m_stall});
    awin = alu_valid && (alu_dst != 0) && !m_stall;
    pop  = (q.size() != 0) && !awin;
    push = mem_valid && ready && (mem_dst != 0);
    if (m_fw) m_busy[m_wrreg] = 1'b0;
    if (pend_set && pend_dst != 0) m_busy[pend_dst] = 1'b1;
    m_rw = 0; m_fw = 0; m_ofc = 2'b00;
    if (awin) begin
      m_rw = 1; m_wrreg = alu_dst; m_wrdata = alu_data;
      if (OVF_EN) m_ofc = {alu_ovf_chk, alu_ovf};
    end else if (pop) begin
      m_rw = 1; m_fw = 1; m_wrreg = q[0].dst; m_wrdata = q[0].data;
    end
    if (m_stall) begin
      m_stall = 0; streak = 0;
    end else if (pop) begin
      streak = 0;
    end else if (q.size() != 0) begin
      streak++;
      if (streak == LIMIT) begin
        m_stall = 1; streak = 0;
      end
    end
    if (pop) void'(q.pop_front());
    if (push) begin
      e.dst = mem_dst; e.data = mem_data;
      q.push_back(e);
    end
    @(posedge clk); #1;
    check("regwrite", {31'd0, regwrite}, {31'd0, m_rw});
    check("of_control", {30'd0, of_control}, {30'd0, m_ofc});
    check("busy_mask", busy_mask, m_busy);
    if (m_rw) begin
      check("wrreg", {27'd0, wrreg}, {27'd0, m_wrreg});
      check("wrdata", wrdata, m_wrdata);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_regwrite"}, {31'd0, regwrite}, 32'd0);
    check({tag, "_wrreg"}, {27'd0, wrreg}, 32'd0);
    check({tag, "_wrdata"}, wrdata, 32'd0);
    check({tag, "_of_control"}, {30'd0, of_control}, 32'd0);
    check({tag, "_busy"}, busy_mask, 32'd0);
    check({tag, "_stall"}, {31'd0, alu_stall}, 32'd0);
    check({tag, "_mem_ready"}, {31'd0, mem_ready}, 32'd1);
  endtask

  int stall_at;

  initial begin
    idle();
    model_reset();
    rst = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1;
    cycle();

    // ALU write
    alu_valid = 1; alu_dst = 5'd5; alu_data = 32'h12345678;
    cycle();
    idle();
    check("alu_wrreg", {27'd0, wrreg}, 32'd5);
    check("alu_wrdata", wrdata, 32'h12345678);
    cycle();

    // Load contention
    pend_set = 1; pend_dst = 5'd8;
    cycle();
    idle();
    check("busy8_set", {31'd0, busy_mask[8]}, 32'd1);
    mem_valid = 1; mem_dst = 5'd8; mem_data = 32'hDEAD0000;
    cycle();
    idle();
    cycle();
    check("load_regwrite", {31'd0, regwrite}, 32'd1);
    check("load_wrreg", {27'd0, wrreg}, 32'd8);
    cycle();
    check("busy8_clear", {31'd0, busy_mask[8]}, 32'd0);

    // Starvation: ALU writes every cycle while one mem entry waits
    stall_at = -1;
    for (int i = 0; i < 8; i++) begin
      alu_valid = 1; alu_dst = 5'(1 + (i % 30)); alu_data = $urandom;
      mem_valid = (i == 0); mem_dst = 5'd12; mem_data = 32'hCAFE0012;
      if (alu_stall && stall_at < 0) stall_at = i;
      cycle();
      if (i == 5) check("starve_wrreg", {27'd0, wrreg}, 32'd12);
    end
    check("starve_cycle", stall_at, 32'd5);
    idle();
    cycle();

    // Full FIFO while the ALU holds the port
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1; alu_dst = 5'd2; alu_data = $urandom;
      mem_valid = 1; mem_dst = 5'(20 + i); mem_data = 32'h0BAD0000 + i;
      if (i == 2) check("full_not_ready", {31'd0, mem_ready}, 32'd0);
      cycle();
    end
    alu_valid = 0;
    mem_valid = 1; mem_dst = 5'd22; mem_data = 32'h0BAD0002;
    check("full_pop_cycle_ready", {31'd0, mem_ready}, 32'd0);
    cycle();
    cycle();
    idle();
    repeat (4) cycle();

    // Overflow-checked add to r3
    alu_valid = 1; alu_dst = 5'd3; alu_data = 32'h80000000; alu_ovf = 1; alu_ovf_chk = 1;
    cycle();
    idle();
    check("overflow_ofc", {30'd0, of_control}, OVF_EN ? 32'd3 : 32'd0);
    cycle();

    // Reset mid-operation with two buffered entries and r8 pending
    alu_valid = 1; alu_dst = 5'd4; alu_data = 32'h1;
    pend_set = 1; pend_dst = 5'd8;
    mem_valid = 1; mem_dst = 5'd9; mem_data = 32'h99;
    cycle();
    pend_set = 0; mem_dst = 5'd10; mem_data = 32'hAA;
    cycle();
    check("pre_reset_busy", busy_mask, 32'h100);
    check("pre_reset_full", {31'd0, mem_ready}, 32'd0);
    idle();
    rst = 0;
    #2;
    check_reset_outputs("midreset");
    model_reset();
    @(posedge clk); #1;
    rst = 1;
    repeat (4) cycle();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      alu_valid   = ($urandom_range(0, 1) == 1);
      alu_dst     = 5'($urandom_range(0, 31));
      alu_data    = $urandom;
      alu_ovf     = 1'($urandom_range(0, 1));
      alu_ovf_chk = 1'($urandom_range(0, 1));
      mem_valid   = ($urandom_range(0, 1) == 1);
      mem_dst     = 5'($urandom_range(0, 31));
      mem_data    = $urandom;
      pend_set    = ($urandom_range(0, 3) == 0);
      pend_dst    = 5'($urandom_range(0, 31));
      cycle();
    end
    idle();
    repeat (8) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
